alu: RTL and testbench

16-bit registered arithmetic/logic unit for the RVCPU datapath. It takes two operands and a 4-bit opcode and produces a result plus status flags. Outputs are registered one clock after an enabled operation is presented. The block is the execute-stage compute element and contains no memory or multi-cycle state beyond its output registers.

---
 rtl/alu_if.sv | 26 ++
 rtl/alu.sv | 115 +++++++++++
 tb/tb_alu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// Operand/opcode bundle and registered status bundle between the execute
// stage and the ALU.
interface alu_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             valid;

  modport master (
    output en, A, B, opcode,
    input  result, zero, negative, carry, overflow, valid
  );

  modport slave (
    input  en, A, B, opcode,
    output result, zero, negative, carry, overflow, valid
  );
endinterface

// File: rtl/alu.sv
// Registered 16-opcode arithmetic/logic unit for the execute stage: operands
// captured on an enabled edge, result and flags presented one cycle later.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_NOR   = 4'b1010,
    OP_NOT   = 4'b1011,
    OP_ROL   = 4'b1100,
    OP_ROR   = 4'b1101,
    OP_PASSA = 4'b1110,
    OP_PASSB = 4'b1111
  } op_e;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, negative_q, valid_q;

  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     rsh;
  logic             a_msb, b_msb;

  assign a_msb = bus.A[WIDTH-1];
  assign b_msb = bus.B[WIDTH-1];
  assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
  // The extra top bit of the difference is the unsigned borrow.
  assign sub_w = {1'b0, bus.A} - {1'b0, bus.B};
  assign sh    = bus.B[SHW-1:0];
  // Complementary rotate distance; at sh == 0 it equals WIDTH and the
  // wrapped half shifts out to zero, leaving A unchanged.
  assign rsh   = WIDTH_L - {1'b0, sh};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no
    // opcode path can leave a value unassigned and infer a latch.
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (op_e'(bus.opcode))
      OP_ADD: begin
        result_d   = add_w[WIDTH-1:0];
        carry_d    = add_w[WIDTH];
        overflow_d = (a_msb == b_msb) && (add_w[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        result_d   = sub_w[WIDTH-1:0];
        carry_d    = sub_w[WIDTH];
        overflow_d = (a_msb != b_msb) && (sub_w[WIDTH-1] != a_msb);
      end
      OP_AND:   result_d = bus.A & bus.B;
      OP_OR:    result_d = bus.A | bus.B;
      OP_SLL:   result_d = bus.A << sh;
      OP_SRL:   result_d = bus.A >> sh;
      OP_XOR:   result_d = bus.A ^ bus.B;
      OP_SRA:   result_d = $signed(bus.A) >>> sh;
      OP_SLT:   result_d = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU:  result_d = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      OP_NOR:   result_d = ~(bus.A | bus.B);
      OP_NOT:   result_d = ~bus.A;
      OP_ROL:   result_d = (bus.A << sh) | (bus.A >> rsh);
      OP_ROR:   result_d = (bus.A >> sh) | (bus.A << rsh);
      OP_PASSA: result_d = bus.A;
      OP_PASSB: result_d = bus.B;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        result_q   <= result_d;
        zero_q     <= (result_d == '0);
        negative_q <= result_d[WIDTH-1];
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = valid_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors with literal
// expectations, then randomized operations against an arithmetic model.
module tb_alu;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(16)) bus ();
  alu #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
  } exp_t;

  // Reference model: plain integer arithmetic and bit-at-a-time loops.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          s, sa, sb;
    int          n;
    logic [15:0] t;
    e  = '0;
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b % 16);
    t  = a;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b); e.r = s[15:0]; e.c = (s > 65535);
        e.v = (sa + sb > 32767) || (sa + sb < -32768);
      end
      4'd1: begin
        s = int'(a) - int'(b); e.r = s[15:0]; e.c = (a < b);
        e.v = (sa - sb > 32767) || (sa - sb < -32768);
      end
      4'd2:  e.r = a & b;
      4'd3:  e.r = a | b;
      4'd4:  e.r = a << n;
      4'd5:  e.r = a >> n;
      4'd6:  e.r = a ^ b;
      4'd7:  begin repeat (n) t = {t[15], t[15:1]}; e.r = t; end
      4'd8:  e.r = (sa < sb) ? 16'd1 : 16'd0;
      4'd9:  e.r = (a < b) ? 16'd1 : 16'd0;
      4'd10: e.r = ~(a | b);
      4'd11: e.r = ~a;
      4'd12: begin repeat (n) t = {t[14:0], t[15]}; e.r = t; end
      4'd13: begin repeat (n) t = {t[0], t[15:1]}; e.r = t; end
      4'd14: e.r = a;
      default: e.r = b;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] r, input logic z, input logic n,
                           input logic c, input logic v, input logic vld);
    check({tag, ".result"},   bus.result,          r);
    check({tag, ".zero"},     16'(bus.zero),       16'(z));
    check({tag, ".negative"}, 16'(bus.negative),   16'(n));
    check({tag, ".carry"},    16'(bus.carry),      16'(c));
    check({tag, ".overflow"}, 16'(bus.overflow),   16'(v));
    check({tag, ".valid"},    16'(bus.valid),      16'(vld));
  endtask

  // Present inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.en = en; bus.opcode = op; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] r, input logic z, input logic n, input logic c, input logic v);
    step(1'b1, op, a, b);
    check_all(tag, r, z, n, c, v, 1'b1);
  endtask

  logic [15:0] er;
  logic        ez, en_, ec, ev, evld;
  exp_t        e;

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1 check_all("reset", 16'h0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check_all("idle_after_reset", 16'h0, 0, 0, 0, 0, 0);

    dir("add_basic", 4'h0, 16'd10, 16'd20, 16'd30, 0, 0, 0, 0);
    dir("add_ovf",   4'h0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1);
    dir("add_carry", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0);
    dir("sub_basic", 4'h1, 16'd50, 16'd30, 16'd20, 0, 0, 0, 0);
    dir("sub_borrow", 4'h1, 16'd30, 16'd50, 16'hFFEC, 0, 1, 1, 0);
    dir("sub_ovf",   4'h1, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
    dir("and",       4'h2, 16'd85, 16'd170, 16'h0000, 1, 0, 0, 0);
    dir("or",        4'h3, 16'd85, 16'd170, 16'd255, 0, 0, 0, 0);
    dir("xor",       4'h6, 16'd85, 16'd170, 16'd255, 0, 0, 0, 0);
    dir("sll",       4'h4, 16'd12, 16'd2, 16'd48, 0, 0, 0, 0);
    dir("srl",       4'h5, 16'd48, 16'd2, 16'd12, 0, 0, 0, 0);
    dir("sra",       4'h7, 16'h8000, 16'd4, 16'hF800, 0, 1, 0, 0);
    dir("rol",       4'hC, 16'h8001, 16'd1, 16'h0003, 0, 0, 0, 0);
    dir("sll_by16",  4'h4, 16'd1, 16'd16, 16'd1, 0, 0, 0, 0);
    dir("ror",       4'hD, 16'h0001, 16'd1, 16'h8000, 0, 1, 0, 0);
    dir("ror_by0",   4'hD, 16'h1234, 16'h0010, 16'h1234, 0, 0, 0, 0);
    dir("slt",       4'h8, 16'hFFFF, 16'd1, 16'd1, 0, 0, 0, 0);
    dir("sltu",      4'h9, 16'hFFFF, 16'd1, 16'd0, 1, 0, 0, 0);
    dir("nor",       4'hA, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0, 0);
    dir("not",       4'hB, 16'hFFFF, 16'h1234, 16'h0000, 1, 0, 0, 0);
    dir("passa",     4'hE, 16'hABCD, 16'h1111, 16'hABCD, 0, 1, 0, 0);
    dir("passb",     4'hF, 16'hABCD, 16'h1111, 16'h1111, 0, 0, 0, 0);

    // Back-to-back operations, then an idle edge that must hold the last result.
    dir("pipe_add", 4'h0, 16'd100, 16'd200, 16'd300, 0, 0, 0, 0);
    dir("pipe_sub", 4'h1, 16'd1000, 16'd1, 16'd999, 0, 0, 0, 0);
    dir("pipe_or",  4'h3, 16'hF0F0, 16'h0F00, 16'hFFF0, 0, 1, 0, 0);
    step(1'b0, 4'h0, 16'h0001, 16'h0001);
    check_all("pipe_hold", 16'hFFF0, 0, 1, 0, 0, 0);

    // Asynchronous reset mid-cycle with a capture pending.
    dir("pre_reset", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0);
    @(negedge clk);
    bus.en = 1'b1; bus.opcode = 4'h0; bus.A = 16'h7FFF; bus.B = 16'h0001;
    #2 rst = 1'b1;
    #1 check_all("async_reset", 16'h0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("reset_held_en", 16'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; bus.en = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset_idle", 16'h0, 0, 0, 0, 0, 0);

    // Randomized operations; expectation state updates only on enabled edges.
    er = '0; ez = 0; en_ = 0; ec = 0; ev = 0;
    for (int i = 0; i < 400; i++) begin
      logic        ren;
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      ren = ($urandom_range(0, 3) != 0);
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
      step(ren, rop, ra, rb);
      if (ren) begin
        e   = model(rop, ra, rb);
        er  = e.r; ec = e.c; ev = e.v;
        ez  = (e.r == 16'h0);
        en_ = e.r[15];
      end
      evld = ren;
      check_all($sformatf("rand%0d_op%0h", i, rop), er, ez, en_, ec, ev, evld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
